serial_subtractor: RTL and testbench
====================================

Name: serial_subtractor

Overview:
Bit-serial unsigned/two's-complement subtractor computing diff = a - b, LSB first, one bit per clock.
- Datapath is one full-subtractor cell built from two half-subtractors plus a registered borrow.
- It is the subtract counterpart of the team's ripple full-adder cells.
- Trades latency (WIDTH cycles) for a single-bit datapath.
- Used by slow control paths that need area-minimal subtraction.

Parameters:
WIDTH, 8, operand/result width in bits (WIDTH >= 2).
CNT_W, $clog2(WIDTH+1), bit counter width (derived, not user-set).

Ports:
clk  input  1  system clock, rising-edge.
rst_n  input  1  asynchronous active-low reset.
start  input  1  request; sampled in IDLE or DONE only.
a  input  WIDTH  minuend, captured on accepted start.
b  input  WIDTH  subtrahend, captured on accepted start.
diff  output  WIDTH  result a - b mod 2^WIDTH, valid when done=1 and held until the next accepted start.
borrow_out  output  1  final borrow; 1 iff a < b (unsigned); same validity as diff.
busy  output  1  high while in SHIFT.
done  output  1  one-cycle pulse when the result becomes valid.

Behaviour:
- Interface: one clock, clk; reset rst_n is asynchronous and active-low.
- Reset:
  - state=IDLE, counter=0, borrow reg=0.
  - Operand shift registers = 0.
  - diff=0, borrow_out=0, busy=0, done=0.
  - Asserting rst_n low mid-operation aborts immediately. After release the block is in IDLE with no done pulse.
- States:
  - IDLE: start=1 -> load a_sr<=a, b_sr<=b, borrow<=0, cnt<=0, go to SHIFT. Otherwise stay.
  - SHIFT (busy=1):
    - Each cycle: d = a_sr[0]^b_sr[0]^borrow.
    - borrow <= (~a_sr[0]&b_sr[0]) | (~(a_sr[0]^b_sr[0])&borrow).
    - Right-shift a_sr and b_sr; shift d into result MSB; cnt++.
    - When cnt==WIDTH-1 on this cycle: go to DONE. The final borrow is written to borrow_out.
    - start is ignored in SHIFT, with no queuing.
  - DONE: done=1 for exactly this cycle.
    - start=1 -> load and go to SHIFT; the result registers keep the old values until the first shift.
    - Otherwise go to IDLE.
- Latency: start accepted at edge k -> SHIFT occupies edges k+1..k+WIDTH -> done high in the cycle after edge k+WIDTH.
- Back-to-back throughput: one result per WIDTH+1 cycles.
- diff/borrow_out are only updated by the shifting; no change in IDLE.
- Width rules:
  - Arithmetic is modulo 2^WIDTH. No sign extension.
  - borrow_out is the unsigned borrow.
  - a==b -> diff=0, borrow_out=0.

Optional Feature:
Macro: SERIAL_SUB_OVF_EN.
- Defined:
  - Adds output port ovf (1 bit). Its reset value is 0, and it has the same validity and hold rules as diff.
  - ovf = signed two's-complement overflow = (a_msb ^ b_msb) & (a_msb ^ diff_msb).
  - The MSBs of a and b are captured at load.
- Undefined: no ovf port and no extra registers; behaviour is otherwise identical.

Decomposition:
- Package serial_sub_pkg:
  - 2-bit state encoding localparams ST_IDLE=0, ST_SHIFT=1, ST_DONE=2.
  - Default WIDTH constant.
- Sub-module full_subtractor: purely combinational (a, b, bin -> d, bout), built from two half_subtractor instances plus an OR gate for bout. It is instantiated once in the datapath.
- Sequencing (FSM, counter, shift registers) lives in serial_subtractor.

Test Plan:
All scenarios use WIDTH=8.
1. Basic: start with a=0x5A, b=0x23 -> done exactly 9 cycles after the start edge, diff=0x37, borrow_out=0, busy high for 8 cycles.
2. Borrow: a=0x10, b=0x20 -> diff=0xF0, borrow_out=1; a=0x00, b=0x01 -> diff=0xFF, borrow_out=1; a=0xFF, b=0xFF -> diff=0x00, borrow_out=0.
3. Busy protection:
   - Start a=0x09, b=0x04.
   - Pulse start with a=0xFF, b=0x00 during cycle 3 of SHIFT.
   - Required: result diff=0x05, a single done pulse, and no second operation.
4. Back-to-back:
   - Start asserted in the DONE cycle with a=0x80, b=0x7F.
   - Required: the new operation starts without passing through IDLE, giving diff=0x01, borrow_out=0.
   - The previous result is seen for the DONE cycle.
5. Reset mid-op: deassert rst_n during SHIFT cycle 4 -> all outputs 0 asynchronously, no done pulse; the next start a=0x03, b=0x01 gives diff=0x02.
6. (SERIAL_SUB_OVF_EN) Overflow cases:
   - a=0x80, b=0x01 -> diff=0x7F, ovf=1.
   - a=0x7F, b=0xFF -> diff=0x80, ovf=1.
   - a=0x05, b=0x03 -> ovf=0.

Source files
------------

// File: rtl/serial_sub_pkg.sv
// ============================================================================
// Module : serial_sub_pkg
// Brief  : Shared constants and state encoding for the bit-serial subtractor.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package serial_sub_pkg;

    // Default operand/result width.
    localparam int c_DEFAULT_WIDTH = 8;

    // 2-bit sequencer state encoding.
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE  = ST_IDLE,
        S_SHIFT = ST_SHIFT,
        S_DONE  = ST_DONE
    } state_t;

endpackage : serial_sub_pkg

`default_nettype wire

// File: rtl/serial_subtractor_full_sub.sv
// ============================================================================
// Module : half_subtractor / full_subtractor
// Brief  : Combinational one-bit subtract cells. full_subtractor is built from
//          two half_subtractor stages and an OR gate merging their borrows.
// Ports  : half_subtractor: a, b -> d = a ^ b, bout = ~a & b
//          full_subtractor: a, b, bin -> d = a ^ b ^ bin, bout
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module half_subtractor (
    input  logic a,
    input  logic b,
    output logic d,
    output logic bout
);
    assign d    = a ^ b;
    assign bout = ~a & b;
endmodule : half_subtractor

module full_subtractor (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);
    logic w_d1;
    logic w_b1;
    logic w_b2;

    // First stage: a - b.
    half_subtractor u_hs0 (
        .a    (a),
        .b    (b),
        .d    (w_d1),
        .bout (w_b1)
    );

    // Second stage: (a - b) - bin. Its borrow is ~(a ^ b) & bin.
    half_subtractor u_hs1 (
        .a    (w_d1),
        .b    (bin),
        .d    (d),
        .bout (w_b2)
    );

    // The two stage borrows are mutually exclusive, so OR merges them.
    assign bout = w_b1 | w_b2;
endmodule : full_subtractor

`default_nettype wire

// File: rtl/serial_subtractor.sv
// ============================================================================
// Module : serial_subtractor
// Brief  : Bit-serial subtractor, diff = a - b mod 2^WIDTH, LSB first, one bit
//          per clock through a single full-subtractor cell.
// Ports  : clk        - rising-edge clock
//          rst_n      - asynchronous active-low reset
//          start      - request, accepted only in IDLE or DONE
//          a, b       - minuend / subtrahend, captured on accepted start
//          diff       - result, valid with done, held until the next shift
//          borrow_out - unsigned borrow (a < b), same validity as diff
//          ovf        - signed overflow (only when SERIAL_SUB_OVF_EN defined)
//          busy       - high while shifting
//          done       - one-cycle pulse when the result becomes valid
// Config : `define SERIAL_SUB_OVF_EN adds the ovf output.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module serial_subtractor
    import serial_sub_pkg::*;
#(
    parameter  int WIDTH = c_DEFAULT_WIDTH,
    localparam int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out,
`ifdef SERIAL_SUB_OVF_EN
    output logic             ovf,
`endif
    output logic             busy,
    output logic             done
);

    localparam logic [CNT_W-1:0] c_LAST_CNT = CNT_W'(WIDTH - 1);

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_a_sr;
    logic [WIDTH-1:0] r_b_sr;
    logic [WIDTH-1:0] r_res;
    logic             r_borrow;
    logic             r_borrow_out;
`ifdef SERIAL_SUB_OVF_EN
    logic             r_a_msb;
    logic             r_b_msb;
    logic             r_ovf;
`endif

    logic w_d;
    logic w_bout;
    logic w_load;

    full_subtractor u_fs (
        .a    (r_a_sr[0]),
        .b    (r_b_sr[0]),
        .bin  (r_borrow),
        .d    (w_d),
        .bout (w_bout)
    );

    // Requests are honoured only when no operation is in flight.
    assign w_load = start && ((r_state == S_IDLE) || (r_state == S_DONE));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_a_sr       <= '0;
            r_b_sr       <= '0;
            r_res        <= '0;
            r_borrow     <= 1'b0;
            r_borrow_out <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
            r_a_msb      <= 1'b0;
            r_b_msb      <= 1'b0;
            r_ovf        <= 1'b0;
`endif
        end else if (w_load) begin
            // Result registers are left alone so the previous answer stays
            // visible until the first shift of the new operation.
            r_state  <= S_SHIFT;
            r_cnt    <= '0;
            r_a_sr   <= a;
            r_b_sr   <= b;
            r_borrow <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
            r_a_msb  <= a[WIDTH-1];
            r_b_msb  <= b[WIDTH-1];
`endif
        end else begin
            case (r_state)
                S_SHIFT: begin
                    r_a_sr   <= {1'b0, r_a_sr[WIDTH-1:1]};
                    r_b_sr   <= {1'b0, r_b_sr[WIDTH-1:1]};
                    r_res    <= {w_d, r_res[WIDTH-1:1]};
                    r_borrow <= w_bout;
                    r_cnt    <= r_cnt + CNT_W'(1);
                    if (r_cnt == c_LAST_CNT) begin
                        r_state      <= S_DONE;
                        r_borrow_out <= w_bout;
`ifdef SERIAL_SUB_OVF_EN
                        // w_d is the result MSB on the final shift.
                        r_ovf <= (r_a_msb ^ r_b_msb) & (r_a_msb ^ w_d);
`endif
                    end
                end
                S_DONE:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign diff       = r_res;
    assign borrow_out = r_borrow_out;
    assign busy       = (r_state == S_SHIFT);
    assign done       = (r_state == S_DONE);
`ifdef SERIAL_SUB_OVF_EN
    assign ovf        = r_ovf;
`endif

endmodule : serial_subtractor

`default_nettype wire

// File: tb/tb_serial_subtractor.sv
// ============================================================================
// Module : tb_serial_subtractor
// Brief  : Self-checking bench for serial_subtractor (WIDTH = 8). Directed
//          vectors push hand-computed results into a queue; a monitor pops
//          and compares on every done pulse.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_serial_subtractor;

    localparam int WIDTH = 8;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic [WIDTH-1:0] a = '0;
    logic [WIDTH-1:0] b = '0;
    logic [WIDTH-1:0] diff;
    logic             borrow_out;
    logic             busy;
    logic             done;
    logic             ovf_w;

    serial_subtractor #(.WIDTH(WIDTH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .a          (a),
        .b          (b),
        .diff       (diff),
        .borrow_out (borrow_out),
`ifdef SERIAL_SUB_OVF_EN
        .ovf        (ovf_w),
`endif
        .busy       (busy),
        .done       (done)
    );

`ifndef SERIAL_SUB_OVF_EN
    assign ovf_w = 1'b0;
`endif

    always #5 clk = ~clk;

    typedef struct packed {
        logic [WIDTH-1:0] d;
        logic             bo;
        logic             ov;
    } exp_t;

    exp_t q[$];
    int   vectors = 0;
    int   errors  = 0;
    int   n_done  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    // Monitor: compares every presented result with the oldest expectation.
    always @(negedge clk) begin
        if (rst_n && done) begin
            exp_t e;
            n_done++;
            if (q.size() == 0) begin
                check("unexpected_done", 32'd1, 32'd0);
            end else begin
                e = q.pop_front();
                check("diff", 32'(diff), 32'(e.d));
                check("borrow_out", 32'(borrow_out), 32'(e.bo));
`ifdef SERIAL_SUB_OVF_EN
                check("ovf", 32'(ovf_w), 32'(e.ov));
`endif
            end
        end
    end

    // Issue one operation at a negedge and return at the negedge where done
    // is seen. lat counts negedges after the start edge; nb counts busy ones.
    task automatic do_op(input logic [7:0] ia, input logic [7:0] ib, input logic [7:0] ed,
                         input logic eb, input logic eo, output int lat, output int nb);
        exp_t e;
        e.d = ed; e.bo = eb; e.ov = eo;
        q.push_back(e);
        a = ia; b = ib; start = 1'b1;
        lat = 0; nb = 0;
        for (int i = 0; i < 4 * WIDTH; i++) begin
            @(negedge clk);
            start = 1'b0;
            lat++;
            if (busy) nb++;
            if (done) break;
        end
        if (!done) check("done_timeout", 32'd0, 32'd1);
    endtask

    typedef struct {
        logic [7:0] a, b, d;
        logic       bo, ov;
    } vec_t;

    vec_t vecs[6] = '{
        '{8'h10, 8'h20, 8'hF0, 1'b1, 1'b0},
        '{8'h00, 8'h01, 8'hFF, 1'b1, 1'b0},
        '{8'hFF, 8'hFF, 8'h00, 1'b0, 1'b0},
        '{8'h80, 8'h01, 8'h7F, 1'b0, 1'b1},
        '{8'h7F, 8'hFF, 8'h80, 1'b1, 1'b1},
        '{8'h05, 8'h03, 8'h02, 1'b0, 1'b0}
    };

    initial begin
        int lat, nb, base;

        // Reset state.
        #12;
        check("rst_diff", 32'(diff), 32'd0);
        check("rst_borrow", 32'(borrow_out), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_ovf", 32'(ovf_w), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Basic: latency and busy length.
        do_op(8'h5A, 8'h23, 8'h37, 1'b0, 1'b0, lat, nb);
        check("latency", 32'(lat), 32'(WIDTH + 1));
        check("busy_cycles", 32'(nb), 32'(WIDTH));
        repeat (4) @(negedge clk);
        check("idle_hold_diff", 32'(diff), 32'h37);
        check("idle_busy", 32'(busy), 32'd0);

        // Borrow and overflow vectors.
        foreach (vecs[i]) begin
            do_op(vecs[i].a, vecs[i].b, vecs[i].d, vecs[i].bo, vecs[i].ov, lat, nb);
            @(negedge clk);
        end

        // Busy protection: a start in SHIFT cycle 3 is ignored.
        base = n_done;
        q.push_back('{d: 8'h05, bo: 1'b0, ov: 1'b0});
        a = 8'h09; b = 8'h04; start = 1'b1;
        @(negedge clk); start = 1'b0;
        @(negedge clk);
        @(negedge clk); a = 8'hFF; b = 8'h00; start = 1'b1;
        @(negedge clk); start = 1'b0;
        repeat (3 * WIDTH) @(negedge clk);
        check("single_done", 32'(n_done - base), 32'd1);

        // Back-to-back: start in the DONE cycle skips IDLE.
        do_op(8'h33, 8'h11, 8'h22, 1'b0, 1'b0, lat, nb);
        do_op(8'h80, 8'h7F, 8'h01, 1'b0, 1'b1, lat, nb);
        check("b2b_busy_cycles", 32'(nb), 32'(WIDTH));
        check("b2b_latency", 32'(lat), 32'(WIDTH + 1));
        @(negedge clk);

        // Reset mid-operation.
        base = n_done;
        a = 8'hFF; b = 8'h00; start = 1'b1;
        @(negedge clk); start = 1'b0;
        repeat (3) @(negedge clk);
        check("pre_rst_busy", 32'(busy), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("arst_diff", 32'(diff), 32'd0);
        check("arst_borrow", 32'(borrow_out), 32'd0);
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_done", 32'(done), 32'd0);
        check("arst_ovf", 32'(ovf_w), 32'd0);
        @(negedge clk); rst_n = 1'b1;
        repeat (2 * WIDTH) @(negedge clk);
        check("no_done_after_rst", 32'(n_done - base), 32'd0);
        do_op(8'h03, 8'h01, 8'h02, 1'b0, 1'b0, lat, nb);
        repeat (3) @(negedge clk);

        check("queue_drained", 32'(q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule : tb_serial_subtractor

`default_nettype wire
